// File: rtl/steer_slew_ctrl.sv
// -----------------------------------------------------------------------------
// steer_slew_ctrl
//
// Slew-rate-limited steering servo angle controller.
//
// Two requesters compete for the steering target:
//   * manual : pos_dir / neg_dir push the wheel to MAX_ANGLE / MIN_ANGLE.
//              A request exists only when exactly one of the two is high.
//   * auto   : tgt_valid / tgt_angle handshake with tgt_ready. The target is
//              clamped into [MIN_ANGLE, MAX_ANGLE] before it is stored.
// Manual always wins. Manual may retarget an ongoing slew; auto may not.
//
// The output angle walks toward the stored target one degree every STEP_DIV
// clocks. After arriving, the block sits in HOLD. If nothing new arrives for
// HOLD_CYCLES clocks, it slews back to CENTER_ANGLE by itself and then
// drops to IDLE.
//
// Ports
//   clk        : sole clock; all state changes on its rising edge
//   nrst       : asynchronous active-low reset
//   pos_dir    : manual request toward MAX_ANGLE
//   neg_dir    : manual request toward MIN_ANGLE
//   tgt_valid  : auto requester offers tgt_angle
//   tgt_angle  : auto target angle, unsigned degrees
//   tgt_ready  : auto target taken on an edge where tgt_valid && tgt_ready
//   angle      : registered, slew-limited servo angle
//   busy       : high while slewing
//   src        : owner of the current target
//                (00 none, 01 manual, 10 auto, 11 center-return)
// -----------------------------------------------------------------------------
module steer_slew_ctrl #(
    parameter logic [15:0] STEP_DIV     = 16'd50000,
    parameter logic [23:0] HOLD_CYCLES  = 24'd5_000_000,
    parameter logic [7:0]  MIN_ANGLE    = 8'd70,
    parameter logic [7:0]  MAX_ANGLE    = 8'd110,
    parameter logic [7:0]  CENTER_ANGLE = 8'd90
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       pos_dir,
    input  logic       neg_dir,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_angle,
    output logic       tgt_ready,
    output logic [7:0] angle,
    output logic       busy,
    output logic [1:0] src
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLEW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE   = 2'b00;
    localparam logic [1:0] SRC_MANUAL = 2'b01;
    localparam logic [1:0] SRC_AUTO   = 2'b10;
    localparam logic [1:0] SRC_CENTER = 2'b11;

    // Terminal counts: the step happens on the cycle the counter sits at
    // STEP_DIV-1, so the first move lands STEP_DIV cycles after entering SLEW.
    localparam logic [15:0] STEP_LAST = STEP_DIV - 16'd1;
    localparam logic [23:0] HOLD_LAST = HOLD_CYCLES - 24'd1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [7:0]  angle_q,    angle_d;
    logic [7:0]  target_q,   target_d;
    logic [1:0]  src_q,      src_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [23:0] hold_cnt_q, hold_cnt_d;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic       manual_req;
    logic [7:0] manual_tgt;
    logic [7:0] auto_tgt;
    logic [7:0] req_tgt;
    logic       auto_take;

    // Both direction inputs high cancel each other out.
    assign manual_req = pos_dir ^ neg_dir;
    assign manual_tgt = pos_dir ? MAX_ANGLE : MIN_ANGLE;

    always_comb begin
        auto_tgt = tgt_angle;
        if (tgt_angle < MIN_ANGLE) begin
            auto_tgt = MIN_ANGLE;
        end else if (tgt_angle > MAX_ANGLE) begin
            auto_tgt = MAX_ANGLE;
        end
    end

    // Ready is gated by nrst so an auto requester never sees a handshake
    // while the block is held in reset. A pending manual request masks ready,
    // which leaves a simultaneous auto offer unconsumed.
    assign tgt_ready = nrst & (state_q != ST_SLEW) & ~manual_req;
    assign auto_take = tgt_valid & tgt_ready;
    assign req_tgt   = manual_req ? manual_tgt : auto_tgt;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        angle_d    = angle_q;
        target_d   = target_q;
        src_d      = src_q;
        step_cnt_d = step_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (manual_req || auto_take) begin
                    target_d = req_tgt;
                    src_d    = manual_req ? SRC_MANUAL : SRC_AUTO;
                    // Already there: skip the slew, restart the hold window.
                    if (req_tgt == angle_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_SLEW;
                        step_cnt_d = '0;
                    end
                end else if (state_q == ST_HOLD) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        target_d   = CENTER_ANGLE;
                        src_d      = SRC_CENTER;
                        state_d    = ST_SLEW;
                        step_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 24'd1;
                    end
                end
            end

            ST_SLEW: begin
                // Manual preemption retargets immediately; the step counter
                // keeps its phase so the slew rate is never exceeded.
                if (manual_req) begin
                    target_d = manual_tgt;
                    src_d    = SRC_MANUAL;
                end

                if (angle_q == target_d) begin
                    if (src_d == SRC_CENTER) begin
                        state_d = ST_IDLE;
                        src_d   = SRC_NONE;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    if (target_d > angle_q) begin
                        angle_d = angle_q + 8'd1;
                    end else begin
                        angle_d = angle_q - 8'd1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            angle_q    <= CENTER_ANGLE;
            target_q   <= CENTER_ANGLE;
            src_q      <= SRC_NONE;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            angle_q    <= angle_d;
            target_q   <= target_d;
            src_q      <= src_d;
            step_cnt_q <= step_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign angle = angle_q;
    assign busy  = (state_q == ST_SLEW);
    assign src   = src_q;

endmodule

// File: tb/tb_steer_slew_ctrl.sv
// -----------------------------------------------------------------------------
// tb_steer_slew_ctrl
//
// Scoreboard bench for steer_slew_ctrl with STEP_DIV=4, HOLD_CYCLES=20.
// The driver plans each request with a trajectory model (start angle, end
// angle, one degree per step period, hold window length) and pushes every
// expected change of {angle, src, busy} together with the clock edge on which
// it must appear. A monitor watches the outputs on falling edges and pops one
// expected entry for every change it observes.
// -----------------------------------------------------------------------------
module tb_steer_slew_ctrl;

    localparam int SD   = 4;
    localparam int HC   = 20;
    localparam int AMIN = 70;
    localparam int AMAX = 110;
    localparam int ACTR = 90;
    localparam int BIG  = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       nrst;
    logic       pos_dir;
    logic       neg_dir;
    logic       tgt_valid;
    logic [7:0] tgt_angle;
    logic       tgt_ready;
    logic [7:0] angle;
    logic       busy;
    logic [1:0] src;

    steer_slew_ctrl #(
        .STEP_DIV    (16'd4),
        .HOLD_CYCLES (24'd20),
        .MIN_ANGLE   (8'd70),
        .MAX_ANGLE   (8'd110),
        .CENTER_ANGLE(8'd90)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pos_dir   (pos_dir),
        .neg_dir   (neg_dir),
        .tgt_valid (tgt_valid),
        .tgt_angle (tgt_angle),
        .tgt_ready (tgt_ready),
        .angle     (angle),
        .busy      (busy),
        .src       (src)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; an output change caused by edge n is
    // stamped n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int t;
        int a;
        int s;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  last_a = ACTR;
    int  last_s = 0;
    int  last_b = 0;

    // Reference model state
    int m_angle  = ACTR;
    int m_src    = 0;
    int m_mode   = 0;   // 0 idle, 1 holding
    int m_hold   = 0;   // edge at which the hold window (re)started
    int m_settle = 0;   // earliest edge at which the block is not slewing

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic int ref_clamp(input int t);
        if (t < AMIN) return AMIN;
        if (t > AMAX) return AMAX;
        return t;
    endfunction

    // Record an expected visible output state; repeated states are no event.
    task automatic expect_ev(input int t, input int a, input int s, input int b);
        ev_t e;
        if (a != last_a || s != last_s || b != last_b) begin
            e.t = t; e.a = a; e.s = s; e.b = b;
            exp_q.push_back(e);
            last_a = a; last_s = s; last_b = b;
        end
    endtask

    // Trajectory of a slew entered on edge t_entry with owner s. Steps land on
    // edges origin + SD*k (k >= 1) after t_entry. Steps at or after t_stop are
    // not planned (t_settle = -1 then). Arrival is seen one edge after the
    // last step; a center-return then leaves src at 00.
    task automatic plan_slew(input int a, input int c, input int s, input int origin,
                             input int t_entry, input int t_stop,
                             output int t_settle, output int a_end);
        int cur;
        int k;
        int te;
        cur = a;
        te  = t_entry;
        expect_ev(t_entry, cur, s, 1);
        k = (t_entry - origin) / SD + 1;
        while (cur != c) begin
            te = origin + SD * k;
            if (te >= t_stop) begin
                t_settle = -1;
                a_end    = cur;
                return;
            end
            cur = (c > cur) ? cur + 1 : cur - 1;
            expect_ev(te, cur, s, 1);
            k++;
        end
        t_settle = te + 1;
        a_end    = cur;
        expect_ev(t_settle, cur, (s == 3) ? 0 : s, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // Common tail for a request taken on edge t0 from IDLE/HOLD.
    task automatic plan_request(input int c, input int s, input int t0);
        int ts;
        int ae;
        if (c == m_angle) begin
            expect_ev(t0, c, s, 0);
            m_hold = t0;
        end else begin
            plan_slew(m_angle, c, s, t0, t0, BIG, ts, ae);
            m_hold = ts;
        end
        m_angle  = c;
        m_src    = s;
        m_mode   = 1;
        m_settle = m_hold;
    endtask

    task automatic issue_auto(input int t, input int delay);
        int  t0;
        int  c;
        logic slewing;
        wait_to(m_settle + delay);
        tgt_valid = 1'b1;
        tgt_angle = t[7:0];
        #1;
        chk("tgt_ready_free", int'(tgt_ready), 1);
        t0 = cyc + 1;
        c  = ref_clamp(t);
        slewing = (c != m_angle);
        plan_request(c, 2, t0);
        $display("txn auto   tgt=%0d -> %0d accepted @%0d settle @%0d", t, c, t0, m_settle);
        tick();
        tgt_valid = 1'b0;
        #1;
        if (slewing) chk("tgt_ready_slewing", int'(tgt_ready), 0);
    endtask

    // Manual pulse with a competing auto offer on the same cycle.
    task automatic issue_manual(input int dir, input int delay);
        int t0;
        int c;
        wait_to(m_settle + delay);
        pos_dir   = (dir != 0);
        neg_dir   = (dir == 0);
        tgt_valid = 1'b1;
        tgt_angle = 8'($urandom_range(0, 255));
        #1;
        chk("tgt_ready_manual", int'(tgt_ready), 0);
        t0 = cyc + 1;
        c  = (dir != 0) ? AMAX : AMIN;
        plan_request(c, 1, t0);
        $display("txn manual dir=%0d -> %0d taken @%0d settle @%0d", dir, c, t0, m_settle);
        tick();
        pos_dir   = 1'b0;
        neg_dir   = 1'b0;
        tgt_valid = 1'b0;
    endtask

    task automatic let_expire();
        int e;
        int ts;
        int ae;
        if (m_mode == 1) begin
            e = m_hold + HC;
            plan_slew(m_angle, ACTR, 3, e, e, BIG, ts, ae);
            $display("txn return from %0d starts @%0d idle @%0d", m_angle, e, ts);
            m_angle  = ACTR;
            m_src    = 0;
            m_mode   = 0;
            m_settle = ts;
        end
        wait_to(m_settle + 1);
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        int   p_a;
        int   p_s;
        int   p_b;
        int   a;
        int   s;
        int   b;
        ev_t  e;
        p_a = ACTR; p_s = 0; p_b = 0;
        forever begin
            @(negedge clk);
            a = int'(angle);
            s = int'(src);
            b = int'(busy);
            if (a != p_a || s != p_s || b != p_b) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event @cyc %0d: got angle=%0d src=%0d busy=%0d, nothing expected",
                             cyc, a, s, b);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cyc || e.a != a || e.s != s || e.b != b) begin
                        n_fail++;
                        $display("FAIL output_event: got cyc=%0d angle=%0d src=%0d busy=%0d, expected cyc=%0d angle=%0d src=%0d busy=%0d",
                                 cyc, a, s, b, e.t, e.a, e.s, e.b);
                    end
                end
                p_a = a; p_s = s; p_b = b;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int t0;
        int tp;
        int tr;
        int ts;
        int ae;
        int ae2;
        int j;
        int r;
        int d;

        nrst      = 1'b1;
        pos_dir   = 1'b0;
        neg_dir   = 1'b0;
        tgt_valid = 1'b0;
        tgt_angle = 8'd0;
        #1;
        nrst = 1'b0;
        #1;
        chk("rst_angle", int'(angle), ACTR);
        chk("rst_src", int'(src), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tgt_ready), 0);

        tick(); tick(); tick();
        nrst = 1'b1;
        #1;
        chk("rel_ready", int'(tgt_ready), 1);
        chk("rel_angle", int'(angle), ACTR);
        chk("rel_src", int'(src), 0);
        chk("rel_busy", int'(busy), 0);
        $display("txn reset released @%0d", cyc);
        m_settle = cyc;

        // Basic slew to 100, then idle hold expiry back to center.
        issue_auto(100, 0);
        let_expire();

        // Clamping on both sides.
        issue_auto(200, 0);
        issue_auto(10, 3);
        let_expire();

        // Manual preemption while slewing toward 70, at angle 85.
        wait_to(m_settle + 2);
        tgt_valid = 1'b1;
        tgt_angle = 8'd10;
        #1;
        chk("tgt_ready_pre", int'(tgt_ready), 1);
        t0 = cyc + 1;
        tick();
        tgt_valid = 1'b0;
        tp = t0 + SD * 5 + 2;
        plan_slew(ACTR, AMIN, 2, t0, t0, tp, ts, ae);
        wait_to(tp - 1);
        pos_dir   = 1'b1;
        tgt_valid = 1'b1;
        tgt_angle = 8'd80;
        #1;
        chk("tgt_ready_preempt", int'(tgt_ready), 0);
        tick();
        pos_dir = 1'b0;
        #1;
        chk("tgt_ready_slew_hold", int'(tgt_ready), 0);
        plan_slew(ae, AMAX, 1, t0, tp, BIG, ts, ae2);
        $display("txn preempt at angle %0d @%0d settle %0d @%0d", ae, tp, ae2, ts);
        wait_to(ts - 2);
        tgt_valid = 1'b0;
        m_angle  = AMAX;
        m_src    = 1;
        m_mode   = 1;
        m_hold   = ts;
        m_settle = ts;

        // Both directions high: no manual request, auto goes through.
        wait_to(m_settle + 3);
        pos_dir   = 1'b1;
        neg_dir   = 1'b1;
        tgt_valid = 1'b1;
        tgt_angle = 8'd80;
        #1;
        chk("tgt_ready_both_dir", int'(tgt_ready), 1);
        t0 = cyc + 1;
        tick();
        tgt_valid = 1'b0;
        pos_dir   = 1'b0;
        neg_dir   = 1'b0;
        j  = $urandom_range(1, 5);
        tr = t0 + SD * j + 1;
        plan_slew(AMAX, 80, 2, t0, t0, tr + 1, ts, ae);
        wait_to(tr);

        // Reset in the middle of that slew.
        nrst = 1'b0;
        expect_ev(tr, ACTR, 0, 0);
        #1;
        chk("midrst_angle", int'(angle), ACTR);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_src", int'(src), 0);
        chk("midrst_ready", int'(tgt_ready), 0);
        $display("txn reset mid-slew at angle %0d @%0d", ae, tr);
        tick(); tick(); tick();
        nrst = 1'b1;
        #1;
        chk("midrst_rel_ready", int'(tgt_ready), 1);
        m_angle  = ACTR;
        m_src    = 0;
        m_mode   = 0;
        m_settle = cyc;
        wait_to(cyc + 30);

        // Random mix.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 99);
            d = (m_mode == 1) ? $urandom_range(0, HC - 2) : $urandom_range(0, 6);
            if (r < 55) begin
                issue_auto($urandom_range(0, 255), d);
            end else if (r < 85) begin
                issue_manual($urandom_range(0, 1), d);
            end else begin
                let_expire();
            end
        end
        let_expire();
        wait_to(cyc + 10);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/steer_slew_ctrl.md
STEER_SLEW_CTRL -- requirements
Module: steer_slew_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 16'd50000: clock cycles per 1-degree angle step.
REQ-002 SHALL have parameter HOLD_CYCLES, default 24'd5_000_000: idle cycles in HOLD before auto-return to center.
REQ-003 SHALL have parameters MIN_ANGLE 8'd70, MAX_ANGLE 8'd110, CENTER_ANGLE 8'd90: steering limits and center, in degrees.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-005 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pos_dir, input, 1: manual request, steer to MAX_ANGLE.
REQ-007 SHALL have port neg_dir, input, 1: manual request, steer to MIN_ANGLE.
REQ-008 SHALL have port tgt_valid, input, 1: auto requester offers tgt_angle.
REQ-009 SHALL have port tgt_angle, input, 8: auto target angle, unsigned degrees.
REQ-010 SHALL have port tgt_ready, output, 1: auto target accepted when tgt_valid and tgt_ready are both high on a clock edge.
REQ-011 SHALL have port angle, output, 8: registered slew-limited servo angle.
REQ-012 SHALL have port busy, output, 1: high while state is SLEW.
REQ-013 SHALL have port src, output, 2: owner of current target; 00 none, 01 manual, 10 auto, 11 center-return.

Function
REQ-014 SHALL define manual_req as pos_dir XOR neg_dir; both high or both low SHALL mean no manual request.
REQ-015 SHALL give manual priority over auto: tgt_ready = nrst AND (state != SLEW) AND NOT manual_req, combinational.
REQ-016 SHALL clamp an accepted auto target to [MIN_ANGLE, MAX_ANGLE] before storing it.
REQ-017 SHALL implement states IDLE, SLEW and HOLD.
REQ-018 In IDLE or HOLD, a manual_req or an accepted auto target SHALL load the target and set src to 01 or 10; the next state SHALL be SLEW, or HOLD if target equals angle.
REQ-019 In SLEW, manual_req SHALL retarget at once (preemption), set src=01, and leave the step counter running; auto requests SHALL be refused.
REQ-020 The step counter SHALL clear on entry to SLEW; angle SHALL move by exactly 1 toward target on the cycle the counter reaches STEP_DIV-1, then the counter SHALL wrap to 0.
REQ-021 The first angle change after entry to SLEW SHALL therefore appear STEP_DIV cycles after entry.
REQ-022 When angle equals target in SLEW: if src=11, go to IDLE and set src=00; otherwise go to HOLD and clear the hold counter.
REQ-023 In HOLD with no request, the hold counter SHALL increment.
REQ-024 When the hold counter reaches HOLD_CYCLES-1, the block SHALL set target=CENTER_ANGLE and src=11, then enter SLEW.
REQ-025 angle SHALL never leave [MIN_ANGLE, MAX_ANGLE] and SHALL never change by more than 1 per step period.
REQ-026 If manual_req and tgt_valid occur on the same cycle, manual SHALL win and the auto target SHALL NOT be consumed.

Reset
REQ-027 While nrst is low: angle=CENTER_ANGLE, state=IDLE, src=00, busy=0, tgt_ready=0, and all counters and target cleared to CENTER_ANGLE or 0.
REQ-028 A reset asserted mid-SLEW SHALL take effect immediately and asynchronously; no residual target SHALL remain after release.

Verification (STEP_DIV=4, HOLD_CYCLES=20)
REQ-029 Reset, then release -> angle=90, src=00, busy=0, tgt_ready=1 on first cycle after release.
REQ-030 Auto tgt_angle=100 accepted -> busy=1, src=10, angle 91 after 4 cycles, 100 after 40 cycles, then HOLD with busy=0.
REQ-031 Auto tgt_angle=200 -> settles at 110; auto tgt_angle=10 -> settles at 70.
REQ-032 pos_dir pulse while slewing toward 70 at angle 85 -> src=01, angle reverses to 86 next step, settles at 110; concurrent tgt_valid held high is not accepted.
REQ-033 HOLD at 100 with no requests for 20 cycles -> src=11, angle steps down to 90, then IDLE with src=00.
REQ-034 pos_dir=neg_dir=1 with tgt_valid, tgt_angle=80 -> auto accepted, src=10; separately, nrst low mid-SLEW -> angle=90 immediately.
